// File: rtl/ctx_save_restore_pkg.sv
// Shared types and defaults for the register-context save/restore engine.
package ctx_save_restore_pkg;

    localparam int unsigned DW_DEFAULT   = 16;
    localparam int unsigned NREG_DEFAULT = 16;
    localparam int unsigned CNT_W        = 5;
    localparam int unsigned SEL_W        = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_REQ,
        ST_WB,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ctx_prienc.sv
// Lowest-set-bit priority encoder: index of the least significant 1 in vec.
module ctx_prienc
    import ctx_save_restore_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEFAULT
) (
    input  logic [NREG-1:0]  vec,
    output logic [SEL_W-1:0] idx,
    output logic             valid
);

    // Scan from the top so the lowest set bit is the last one to win.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = int'(NREG) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = SEL_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ctx_save_restore.sv
// Masked register-file save/restore engine moving one register per memory request.
module ctx_save_restore
    import ctx_save_restore_pkg::*;
#(
    parameter int unsigned DW   = DW_DEFAULT,
    parameter int unsigned NREG = NREG_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [NREG-1:0]  mask,
    input  logic [DW-1:0]    base,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic [SEL_W-1:0] rf_sel,
    input  logic [DW-1:0]    rf_rdata,
    output logic [DW-1:0]    rf_wdata,
    output logic             rf_wrt,
    output logic             mem_req,
    output logic             mem_we,
    output logic [DW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic             mem_ack,
    input  logic [DW-1:0]    mem_rdata
);

    state_t           state, state_n;
    logic [NREG-1:0]  rem, rem_n, rem_clr, pe_vec;
    logic [DW-1:0]    base_q, base_n;
    logic             dir_q, dir_n;
    logic [CNT_W-1:0] cnt_n;
    logic [SEL_W-1:0] sel_n, pe_idx;
    logic             pe_valid;
    logic [DW-1:0]    rf_wdata_n, mem_addr_n, mem_wdata_n;
    logic             mem_we_n;

    // Remaining mask with the current register retired.
    assign rem_clr = rem & ~(NREG'(1) << rf_sel);

    // rf_sel is registered one step ahead so rf_rdata is settled during SCAN.
    assign pe_vec = (state == ST_IDLE) ? mask : rem_clr;

    ctx_prienc #(.NREG(NREG)) u_prienc (
        .vec   (pe_vec),
        .idx   (pe_idx),
        .valid (pe_valid)
    );

    always_comb begin
        state_n     = state;
        rem_n       = rem;
        base_n      = base_q;
        dir_n       = dir_q;
        cnt_n       = xfer_cnt;
        sel_n       = rf_sel;
        rf_wdata_n  = rf_wdata;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        mem_we_n    = mem_we;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    rem_n   = mask;
                    base_n  = base;
                    dir_n   = dir;
                    cnt_n   = '0;
                    sel_n   = pe_valid ? pe_idx : rf_sel;
                    state_n = pe_valid ? ST_SCAN : ST_DONE;
                end
            end
            ST_SCAN: begin
                mem_addr_n = base_q + DW'(xfer_cnt);
                mem_we_n   = ~dir_q;
                if (!dir_q) begin
                    mem_wdata_n = rf_rdata;
                end
                state_n = ST_REQ;
            end
            ST_REQ: begin
                if (mem_ack) begin
                    mem_we_n = 1'b0;
                    if (dir_q) begin
                        rf_wdata_n = mem_rdata;
                        state_n    = ST_WB;
                    end else begin
                        rem_n   = rem_clr;
                        cnt_n   = xfer_cnt + CNT_W'(1);
                        sel_n   = pe_valid ? pe_idx : rf_sel;
                        state_n = pe_valid ? ST_SCAN : ST_DONE;
                    end
                end
            end
            ST_WB: begin
                rem_n   = rem_clr;
                cnt_n   = xfer_cnt + CNT_W'(1);
                sel_n   = pe_valid ? pe_idx : rf_sel;
                state_n = pe_valid ? ST_SCAN : ST_DONE;
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, datapath and state-decoded strobes all registered from next-state values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rem       <= '0;
            base_q    <= '0;
            dir_q     <= 1'b0;
            xfer_cnt  <= '0;
            rf_sel    <= '0;
            rf_wdata  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_req   <= 1'b0;
            rf_wrt    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            rem       <= rem_n;
            base_q    <= base_n;
            dir_q     <= dir_n;
            xfer_cnt  <= cnt_n;
            rf_sel    <= sel_n;
            rf_wdata  <= rf_wdata_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            mem_we    <= mem_we_n;
            mem_req   <= (state_n == ST_REQ);
            rf_wrt    <= (state_n == ST_WB);
            busy      <= (state_n != ST_IDLE);
            done      <= (state_n == ST_DONE);
        end
    end

endmodule

// File: tb/tb_ctx_save_restore.sv
// Directed bench for ctx_save_restore with a schedule-based reference model.
module tb_ctx_save_restore;

    localparam int unsigned DW   = 16;
    localparam int unsigned NREG = 16;

    logic            clk = 1'b0;
    logic            rst, start, dir;
    logic [NREG-1:0] mask;
    logic [DW-1:0]   base;
    logic            busy, done, rf_wrt, mem_req, mem_we, mem_ack;
    logic [4:0]      xfer_cnt;
    logic [3:0]      rf_sel;
    logic [DW-1:0]   rf_rdata, rf_wdata, mem_addr, mem_wdata, mem_rdata;

    logic [DW-1:0]   rf  [NREG];
    logic [DW-1:0]   mem [65536];

    int vec_cnt = 0, err_cnt = 0;
    int op_seq = 0, op_seen = 0, ops_done = 0;
    int abort_seq = 0, abort_seen = 0;
    int stray_cnt = 0, stray_served = 0;
    int resp_w = 0, wcnt = 0;

    logic          m_active = 1'b0;
    logic          m_dir;
    logic [DW-1:0] m_base;
    int            m_w, m_n, m_p, m_l, m_t;
    int            m_regs [NREG];
    int            done_seen = 0, wrt_seen = 0, req_seen = 0;

    always #5 clk = ~clk;

    ctx_save_restore #(.DW(DW), .NREG(NREG)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dir       (dir),
        .mask      (mask),
        .base      (base),
        .busy      (busy),
        .done      (done),
        .xfer_cnt  (xfer_cnt),
        .rf_sel    (rf_sel),
        .rf_rdata  (rf_rdata),
        .rf_wdata  (rf_wdata),
        .rf_wrt    (rf_wrt),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    assign rf_rdata = rf[rf_sel];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Register file: written on the clock edge whenever the engine strobes rf_wrt.
    initial begin
        for (int i = 0; i < int'(NREG); i++) rf[i] = 16'h4000 + 16'(i);
        rf[0] = 16'h1111;
        rf[1] = 16'h1B1B;
        rf[2] = 16'h2222;
        forever begin
            @(posedge clk);
            if (rf_wrt) rf[rf_sel] <= rf_wdata;
        end
    end

    // Memory responder: acks after resp_w wait cycles; also injects stray acks on request.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        for (int a = 0; a < 65536; a++) mem[a] = 16'hDEAD;
        mem[16'h0200] = 16'hAAAA;
        mem[16'h0201] = 16'h5555;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end else if (stray_served != stray_cnt) begin
                stray_served++;
                mem_ack   = 1'b1;
                mem_rdata = 16'hBEEF;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end else if (mem_req) begin
                if (wcnt == resp_w) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                    if (mem_we) mem[mem_addr] = mem_wdata;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Compare process: expected outputs derived from the per-register cycle schedule.
    initial begin
        int k, ph;
        logic in_req, in_wb;
        forever begin
            @(posedge clk);
            #1;
            if (abort_seq != abort_seen) begin
                abort_seen = abort_seq;
                if (m_active) begin
                    m_active = 1'b0;
                    ops_done++;
                end
            end
            if (op_seq != op_seen) begin
                op_seen   = op_seq;
                m_active  = 1'b1;
                m_t       = 0;
                done_seen = 0;
                wrt_seen  = 0;
                req_seen  = 0;
            end
            if (rst) begin
                chk("rst_busy",      32'(busy),      32'(0));
                chk("rst_done",      32'(done),      32'(0));
                chk("rst_mem_req",   32'(mem_req),   32'(0));
                chk("rst_mem_we",    32'(mem_we),    32'(0));
                chk("rst_rf_wrt",    32'(rf_wrt),    32'(0));
                chk("rst_rf_sel",    32'(rf_sel),    32'(0));
                chk("rst_mem_addr",  32'(mem_addr),  32'(0));
                chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
                chk("rst_rf_wdata",  32'(rf_wdata),  32'(0));
                chk("rst_xfer_cnt",  32'(xfer_cnt),  32'(0));
            end else if (m_active) begin
                m_t++;
                if (m_t < m_l) begin
                    k      = (m_t - 1) / m_p;
                    ph     = (m_t - 1) % m_p;
                    in_req = (m_t < m_l - 1) && (ph >= 1) && (ph <= 1 + m_w);
                    in_wb  = (m_t < m_l - 1) && m_dir && (ph == 2 + m_w);
                    if (done)    done_seen++;
                    if (rf_wrt)  wrt_seen++;
                    if (mem_req) req_seen++;
                    chk("busy",     32'(busy),     32'(1));
                    chk("done",     32'(done),     32'(m_t == m_l - 1));
                    chk("xfer_cnt", 32'(xfer_cnt), 32'((k < m_n) ? k : m_n));
                    chk("mem_req",  32'(mem_req),  32'(in_req));
                    chk("rf_wrt",   32'(rf_wrt),   32'(in_wb));
                    if (in_req) begin
                        chk("mem_addr", 32'(mem_addr), 32'(16'(m_base + 16'(k))));
                        chk("mem_we",   32'(mem_we),   32'(!m_dir));
                        chk("rf_sel",   32'(rf_sel),   32'(m_regs[k]));
                        if (!m_dir) chk("mem_wdata", 32'(mem_wdata), 32'(rf[m_regs[k]]));
                    end
                    if (in_wb) begin
                        chk("wb_rf_sel", 32'(rf_sel),   32'(m_regs[k]));
                        chk("rf_wdata",  32'(rf_wdata), 32'(mem[16'(m_base + 16'(k))]));
                    end
                end else begin
                    chk("end_busy",      32'(busy),      32'(0));
                    chk("end_done",      32'(done),      32'(0));
                    chk("end_xfer_cnt",  32'(xfer_cnt),  32'(m_n));
                    chk("done_pulses",   32'(done_seen), 32'(1));
                    m_active = 1'b0;
                    ops_done++;
                end
            end else begin
                chk("idle_busy",    32'(busy),    32'(0));
                chk("idle_done",    32'(done),    32'(0));
                chk("idle_mem_req", 32'(mem_req), 32'(0));
                chk("idle_rf_wrt",  32'(rf_wrt),  32'(0));
            end
        end
    end

    task automatic start_op(input logic d, input logic [15:0] m, input logic [15:0] b, input int w);
        int n = 0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                m_regs[n] = i;
                n++;
            end
        end
        m_dir  = d;
        m_base = b;
        m_w    = w;
        m_n    = n;
        m_p    = d ? 3 + w : 2 + w;
        m_l    = 2 + n * m_p;
        resp_w = w;
        dir    = d;
        mask   = m;
        base   = b;
        start  = 1'b1;
        op_seq++;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_op();
        for (int c = 0; c < 400 && ops_done != op_seq; c++) @(negedge clk);
        chk("op_timeout", 32'(ops_done), 32'(op_seq));
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        dir   = 1'b0;
        mask  = '0;
        base  = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Save r0, r2 with one wait cycle per request.
        start_op(1'b0, 16'h0005, 16'h0100, 1);
        wait_op();
        chk("save_m100", 32'(mem[16'h0100]), 32'h1111);
        chk("save_m101", 32'(mem[16'h0101]), 32'h2222);
        chk("save_m102", 32'(mem[16'h0102]), 32'hDEAD);
        chk("save_cnt",  32'(xfer_cnt),      32'd2);

        // Empty mask: straight to DONE, no memory traffic.
        start_op(1'b0, 16'h0000, 16'h0500, 0);
        wait_op();
        chk("empty_req",  32'(req_seen), 32'd0);
        chk("empty_cnt",  32'(xfer_cnt), 32'd0);

        // Address wrap at the top of memory.
        start_op(1'b0, 16'h0003, 16'hFFFF, 0);
        wait_op();
        chk("wrap_mFFFF", 32'(mem[16'hFFFF]), 32'h1111);
        chk("wrap_m0000", 32'(mem[16'h0000]), 32'h1B1B);

        // Restore r0, r15 with three wait cycles per request.
        start_op(1'b1, 16'h8001, 16'h0200, 3);
        wait_op();
        chk("rest_r0",   32'(rf[0]),    32'hAAAA);
        chk("rest_r15",  32'(rf[15]),   32'h5555);
        chk("rest_r1",   32'(rf[1]),    32'h1B1B);
        chk("rest_wrts", 32'(wrt_seen), 32'd2);
        chk("rest_cnt",  32'(xfer_cnt), 32'd2);

        // Second start while busy, with changed mask/base/dir held afterwards.
        start_op(1'b0, 16'h00F0, 16'h0400, 1);
        repeat (2) @(negedge clk);
        chk("busy_at_restart", 32'(busy), 32'd1);
        start = 1'b1;
        mask  = 16'h000F;
        base  = 16'h0000;
        dir   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_op();
        chk("busy_cnt",  32'(xfer_cnt),      32'd4);
        chk("busy_m400", 32'(mem[16'h0400]), 32'h4004);
        chk("busy_m403", 32'(mem[16'h0403]), 32'h4007);

        // Reset during the second request of a four-register save.
        start_op(1'b0, 16'h000F, 16'h0300, 2);
        repeat (5) @(negedge clk);
        chk("pre_rst_req", 32'(mem_req),  32'd1);
        chk("pre_rst_cnt", 32'(xfer_cnt), 32'd1);
        rst = 1'b1;
        abort_seq++;
        #1;
        chk("abort_req",  32'(mem_req),  32'd0);
        chk("abort_busy", 32'(busy),     32'd0);
        chk("abort_done", 32'(done),     32'd0);
        chk("abort_cnt",  32'(xfer_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        stray_cnt++;
        repeat (6) @(negedge clk);
        chk("abort_m300", 32'(mem[16'h0300]), 32'hAAAA);
        chk("abort_m301", 32'(mem[16'h0301]), 32'hDEAD);
        chk("abort_m302", 32'(mem[16'h0302]), 32'hDEAD);
        chk("abort_r1",   32'(rf[1]),         32'h1B1B);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ctx_save_restore.md
CTX_SAVE_RESTORE -- requirements
Module: ctx_save_restore

Interface
REQ-001 The block SHALL expose the following parameters:
- DW, default 16, data and address width.
- NREG, default 16, number of architectural registers.
REQ-002 The block SHALL expose the following ports, one per line (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst  in  1  reset: asynchronous, active-high.
- start  in  1  begin a transfer; sampled in IDLE only.
- dir  in  1  0 = save (register file to memory), 1 = restore (memory to register file).
- mask  in  NREG  registers to transfer; bit i selects register i.
- base  in  DW  memory word address of the first transferred register.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- xfer_cnt  out  5  registers transferred so far in the current operation.
- rf_sel  out  4  register index, drives the register-file read select and write select.
- rf_rdata  in  DW  register-file read data (combinational from rf_sel).
- rf_wdata  out  DW  register-file write data.
- rf_wrt  out  1  register-file write enable.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write qualifier (1 = save).
- mem_addr  out  DW  memory word address.
- mem_wdata  out  DW  memory write data.
- mem_ack  in  1  memory completion; any number of wait cycles permitted.
- mem_rdata  in  DW  memory read data, valid in the mem_ack cycle.

Function
REQ-003 The FSM SHALL have states IDLE, SCAN, REQ, WB, DONE; all registers SHALL update on the rising clk edge.
REQ-004 IDLE: on start=1, the block SHALL latch mask, base and dir, clear xfer_cnt, and go to DONE if mask==0, otherwise to SCAN.
REQ-005 SCAN (one cycle): the block SHALL latch into rf_sel the lowest set bit of the remaining mask, then go to REQ.
REQ-006 REQ: mem_req SHALL be 1, mem_addr SHALL be base+xfer_cnt (modulo 2^DW, wrapping), and mem_we SHALL equal the inverted latched dir.
REQ-007 In a REQ save cycle, mem_wdata SHALL equal rf_rdata.
REQ-008 mem_req, mem_addr, mem_we and mem_wdata SHALL stay stable until the cycle in which mem_ack=1.
REQ-009 On mem_ack in save mode, the block SHALL clear the rf_sel bit in the remaining mask and increment xfer_cnt, then go to SCAN if the remaining mask is nonzero, else to DONE.
REQ-010 On mem_ack in restore mode, the block SHALL capture mem_rdata into rf_wdata and go to WB.
REQ-011 WB (one cycle, restore only): rf_wrt SHALL be 1 with the rf_sel and rf_wdata values of that cycle; the block SHALL clear the mask bit and increment xfer_cnt, then go to SCAN or DONE as in REQ-009.
REQ-012 rf_wrt SHALL be 0 in every state except WB.
REQ-013 mem_req SHALL be 0 in every state except REQ.
REQ-014 DONE: done SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE; xfer_cnt SHALL hold its final value until the next accepted start.
REQ-015 start asserted while busy=1 SHALL be ignored; changes to mask, base or dir after acceptance SHALL have no effect.
REQ-016 mem_ack outside REQ SHALL be ignored.
REQ-017 mask=16'hFFFF SHALL yield xfer_cnt=16; memory words SHALL be packed densely in ascending register order regardless of gaps in mask.
REQ-018 Total latency SHALL be 2+N*(2+W) cycles for save and 2+N*(3+W) cycles for restore, where N = popcount(mask) and W = wait cycles per request.

Reset
REQ-019 rst=1 SHALL asynchronously force state IDLE and the following outputs: busy=0, done=0, mem_req=0, mem_we=0, rf_wrt=0, rf_sel=0, mem_addr=0, mem_wdata=0, rf_wdata=0, xfer_cnt=0.
REQ-020 Reset mid-operation SHALL abandon the transfer with no further memory or register-file activity; a pending mem_ack after release SHALL be ignored.

Structure
REQ-021 A shared package SHALL hold the FSM state enumeration and the DW and NREG defaults.
REQ-022 The lowest-set-bit search SHALL be a sub-module ctx_prienc (NREG-bit input, 4-bit index, valid flag).
REQ-023 The block SHALL act on the rising clk edge only; the register file's own write timing is outside this block.

Verification
REQ-024 The bench SHALL cover the following scenarios:
- Save: mask=16'h0005, base=16'h0100, rf r0=16'h1111, r2=16'h2222, mem_ack the cycle after each mem_req. Required: writes 16'h0100<-16'h1111 and 16'h0101<-16'h2222, done once, xfer_cnt=2.
- Restore: mask=16'h8001, base=16'h0200, memory [0x200]=16'hAAAA, [0x201]=16'h5555, 3 wait cycles each. Required: r0=16'hAAAA, r15=16'h5555, rf_wrt exactly 2 cycles, mem_req stable during waits.
- Empty mask: mask=0, start. Required: no mem_req, done pulse 2 cycles after start, xfer_cnt=0.
- Wrap-around: base=16'hFFFF, mask=16'h0003, save. Required: addresses 16'hFFFF then 16'h0000.
- Reset mid-op: rst during the second REQ of mask=16'h000F. Required: mem_req=0 immediately, busy=0, no done, later mem_ack ignored.
- Start while busy: second start with a different mask during the transfer. Required: ignored, original transfer completes with unchanged count.
